// File: rtl/axi_rr_arbiter_if.sv
// axi_rr_arbiter_if: request/grant bundle between requesters and the
// round-robin arbiter.
//   master modport : requester / downstream side (drives requests and READY)
//   slave modport  : arbiter side (drives the registered grant outputs)
interface axi_rr_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
);
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_last;
   logic             sel_ready;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic [N_REQ-1:0] grant_onehot;

   modport master (
      output req_valid,
      output req_last,
      output sel_ready,
      input  grant_valid,
      input  grant_idx,
      input  grant_onehot
   );

   modport slave (
      input  req_valid,
      input  req_last,
      input  sel_ready,
      output grant_valid,
      output grant_idx,
      output grant_onehot
   );
endinterface

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: N_REQ-channel round-robin arbiter with fully registered
// grant outputs. A grant is held until a handshake (VALID & READY on the
// granted channel) releases it; the next grant is then chosen circularly
// from the channel after the one just served, with no idle cycle.
// After reset channel 0 has top priority, and the first grant appears no
// earlier than the second rising ACLK edge after ARESETn is released.
// Optional feature macro: ARB_BURST_LOCK_EN -- when defined, a release also
// requires req_last on the granted channel, so a whole burst keeps the grant.
module axi_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   axi_rr_arbiter_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_armed;
   logic [IDX_W-1:0] r_last_ptr;
   logic             r_grant_valid;
   logic [IDX_W-1:0] r_grant_idx;
   logic [N_REQ-1:0] r_grant_onehot;

   logic [IDX_W-1:0] w_search_base;
   logic [IDX_W-1:0] w_next_idx;
   logic             w_found;
   logic             w_req_at_grant;
   logic             w_handshake;
   logic             w_release;

   // Search starts after last_ptr while idle, after the current grant while busy;
   // on a release last_ptr is loaded with grant_idx, so both views agree.
   always_comb begin
      w_search_base = (r_state == ST_BUSY) ? r_grant_idx : r_last_ptr;
   end

   // Circular first-set-bit search over offsets 1..N_REQ from the base;
   // offset N_REQ lands on the base itself, which yields the back-to-back
   // re-grant when the served channel is the only requester.
   always_comb begin
      int unsigned w_pos;
      logic [IDX_W-1:0] w_pos_idx;
      w_found    = 1'b0;
      w_next_idx = '0;
      w_pos      = 0;
      w_pos_idx  = '0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         w_pos = 32'(w_search_base) + off;
         if (w_pos >= N_REQ) begin
            w_pos = w_pos - N_REQ;
         end
         w_pos_idx = IDX_W'(w_pos);
         if (!w_found && bus.req_valid[w_pos_idx]) begin
            w_found    = 1'b1;
            w_next_idx = w_pos_idx;
         end
      end
   end

   // Handshake on the granted channel, selected through the one-hot register
   // so no index ever reaches past N_REQ-1.
   always_comb begin
      w_req_at_grant = |(bus.req_valid & r_grant_onehot);
      w_handshake    = r_grant_valid & w_req_at_grant & bus.sel_ready;
   end

`ifdef ARB_BURST_LOCK_EN
   logic w_last_at_grant;

   // Release only on the LAST beat of the granted burst.
   always_comb begin
      w_last_at_grant = |(bus.req_last & r_grant_onehot);
      w_release       = w_handshake & w_last_at_grant;
   end
`else
   logic w_unused_last;

   // Every handshake releases; req_last is not consulted.
   always_comb begin
      w_unused_last = ^bus.req_last;
      w_release     = w_handshake;
   end
`endif

   // Grant FSM with registered outputs; r_armed blocks grants on the first
   // edge after reset release.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state        <= ST_IDLE;
         r_armed        <= 1'b0;
         r_last_ptr     <= IDX_W'(N_REQ - 1);
         r_grant_valid  <= 1'b0;
         r_grant_idx    <= '0;
         r_grant_onehot <= '0;
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (r_armed && w_found) begin
                  r_state        <= ST_BUSY;
                  r_grant_valid  <= 1'b1;
                  r_grant_idx    <= w_next_idx;
                  r_grant_onehot <= N_REQ'(1) << w_next_idx;
               end
            end
            ST_BUSY: begin
               if (w_release) begin
                  r_last_ptr <= r_grant_idx;
                  if (w_found) begin
                     r_grant_idx    <= w_next_idx;
                     r_grant_onehot <= N_REQ'(1) << w_next_idx;
                  end else begin
                     r_state        <= ST_IDLE;
                     r_grant_valid  <= 1'b0;
                     r_grant_idx    <= '0;
                     r_grant_onehot <= '0;
                  end
               end
            end
            default: begin
               r_state        <= ST_IDLE;
               r_grant_valid  <= 1'b0;
               r_grant_idx    <= '0;
               r_grant_onehot <= '0;
            end
         endcase
      end
   end

   assign bus.grant_valid  = r_grant_valid;
   assign bus.grant_idx    = r_grant_idx;
   assign bus.grant_onehot = r_grant_onehot;

   // Output invariants: one-hot tracks the index, index stays in range,
   // one-hot is clear whenever no grant is active.
   a_onehot_match : assert property (@(posedge ACLK) disable iff (!ARESETn)
      r_grant_valid |-> (r_grant_onehot == (N_REQ'(1) << r_grant_idx)));
   a_idx_range : assert property (@(posedge ACLK) disable iff (!ARESETn)
      r_grant_valid |-> (32'(r_grant_idx) < N_REQ));
   a_idle_clear : assert property (@(posedge ACLK) disable iff (!ARESETn)
      !r_grant_valid |-> (r_grant_onehot == '0));

endmodule
